ibex_fetch_req_sched: RTL and testbench

Request scheduler sitting between the instruction-side bus interface and the fetch FIFO. It issues word-aligned instruction fetch requests, tracks up to NUM_REQS outstanding bus transactions, and throttles issue on FIFO space. On branches it clears the FIFO and discards the responses of requests issued before the branch. It forwards surviving responses into the FIFO input port.

---
 rtl/ibex_fetch_req_sched.sv | 183 ++++++++++++++++++
 tb/tb_ibex_fetch_req_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_req_sched.sv
// ibex_fetch_req_sched
//
// Schedules word-aligned instruction fetch requests onto the instruction bus.
// It tracks up to NUM_REQS outstanding transactions, throttles issue on FIFO
// space, and on a branch clears the FIFO and drops responses to requests
// issued before the branch.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i                fetch enable from the IF stage
//   branch_i             single-cycle redirect strobe
//   branch_addr_i        redirect target (bit 0 ignored, bit 1 forwarded to FIFO)
//   fifo_ready_i         FIFO can absorb NUM_REQS further responses
//   fifo_clear_o         FIFO clear (equals branch_i)
//   fifo_valid_o         surviving response valid into the FIFO
//   fifo_addr_o          FIFO restart address (unaligned branch target)
//   fifo_rdata_o         response data
//   fifo_err_o           response bus error
//   instr_req_o          bus request
//   instr_gnt_i          bus grant
//   instr_addr_o         bus address, always word aligned
//   instr_rvalid_i       bus response valid
//   instr_rdata_i        bus response data
//   instr_err_i          bus response error
//   busy_o               request pending or transactions outstanding

`timescale 1ns / 1ps

module ibex_fetch_req_sched #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,

    input  logic        fifo_ready_i,
    output logic        fifo_clear_o,
    output logic        fifo_valid_o,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o,
    output logic        fifo_err_o,

    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,

    output logic        busy_o
);

    typedef enum logic [0:0] {StIdle, StWaitGnt} state_e;

    state_e              state_q, state_d;
    logic [31:0]         fetch_addr_q, fetch_addr_d;
    logic [31:0]         stored_addr_q, stored_addr_d;
    // Set when a branch arrives while a request waits for its grant.
    logic                discard_pend_q, discard_pend_d;
    // Thermometer vectors: bit 0 is the oldest outstanding transaction.
    logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
    logic [NUM_REQS-1:0] discard_q, discard_d;

    logic [31:0]         branch_tgt;
    logic                slot_free;
    logic                issue_ok;
    logic                gnt;
    logic                push_discard;
    logic [NUM_REQS-1:0] new_slot;

    assign branch_tgt = {branch_addr_i[31:2], 2'b00};

    // A response retiring in this cycle frees its slot for a same-cycle issue.
    assign slot_free = ~outstanding_q[NUM_REQS-1] | instr_rvalid_i;
    assign issue_ok  = req_i & fifo_ready_i & slot_free;

    always_comb begin
        if (state_q == StWaitGnt) begin
            instr_req_o  = 1'b1;
            instr_addr_o = stored_addr_q;
        end else begin
            instr_req_o  = issue_ok | (branch_i & slot_free);
            instr_addr_o = branch_i ? branch_tgt : fetch_addr_q;
        end
    end

    assign gnt = instr_req_o & instr_gnt_i;

    // Only a request that was already waiting when a branch arrived is stale.
    assign push_discard = (state_q == StWaitGnt) & (branch_i | discard_pend_q);

    always_comb begin
        state_d        = state_q;
        fetch_addr_d   = fetch_addr_q;
        stored_addr_d  = stored_addr_q;
        discard_pend_d = discard_pend_q;

        unique case (state_q)
            StIdle: begin
                if (instr_req_o && !instr_gnt_i) begin
                    state_d        = StWaitGnt;
                    stored_addr_d  = instr_addr_o;
                    discard_pend_d = 1'b0;
                end
                if (gnt) begin
                    fetch_addr_d = instr_addr_o + 32'd4;
                end else if (branch_i) begin
                    fetch_addr_d = branch_tgt;
                end
            end
            StWaitGnt: begin
                if (branch_i) begin
                    discard_pend_d = 1'b1;
                    fetch_addr_d   = branch_tgt;
                end
                if (instr_gnt_i) begin
                    state_d = StIdle;
                    // After a branch, fetch_addr_q already holds the target.
                    if (!branch_i && !discard_pend_q) begin
                        fetch_addr_d = stored_addr_q + 32'd4;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        outstanding_d = outstanding_q;
        discard_d     = discard_q | (outstanding_q & {NUM_REQS{branch_i}});
        new_slot      = '0;
        if (instr_rvalid_i) begin
            outstanding_d = outstanding_d >> 1;
            discard_d     = discard_d >> 1;
        end
        if (gnt) begin
            // First empty position of the thermometer after the pop.
            new_slot      = ~outstanding_d & ((outstanding_d << 1) | NUM_REQS'(1));
            outstanding_d = outstanding_d | new_slot;
            if (push_discard) begin
                discard_d = discard_d | new_slot;
            end
        end
        discard_d = discard_d & outstanding_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            fetch_addr_q   <= '0;
            stored_addr_q  <= '0;
            discard_pend_q <= 1'b0;
            outstanding_q  <= '0;
            discard_q      <= '0;
        end else begin
            state_q        <= state_d;
            fetch_addr_q   <= fetch_addr_d;
            stored_addr_q  <= stored_addr_d;
            discard_pend_q <= discard_pend_d;
            outstanding_q  <= outstanding_d;
            discard_q      <= discard_d;
        end
    end

    assign fifo_valid_o = instr_rvalid_i & ~discard_q[0] & ~branch_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;
    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = branch_addr_i;

    assign busy_o = (state_q == StWaitGnt) | (|outstanding_q);

    RvalidWithoutOutstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> outstanding_q[0]);

    GntWhenFull: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (gnt & outstanding_q[NUM_REQS-1]) |-> instr_rvalid_i);

endmodule

// File: tb/tb_ibex_fetch_req_sched.sv
`timescale 1ns / 1ps

module tb_ibex_fetch_req_sched;

    localparam int NUM_REQS = 2;

    logic        clk_i;
    logic        rst_ni;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        fifo_ready_i;
    logic        fifo_clear_o;
    logic        fifo_valid_o;
    logic [31:0] fifo_addr_o;
    logic [31:0] fifo_rdata_o;
    logic        fifo_err_o;
    logic        instr_req_o;
    logic        instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        busy_o;

    ibex_fetch_req_sched #(
        .NUM_REQS(NUM_REQS)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .fifo_ready_i  (fifo_ready_i),
        .fifo_clear_o  (fifo_clear_o),
        .fifo_valid_o  (fifo_valid_o),
        .fifo_addr_o   (fifo_addr_o),
        .fifo_rdata_o  (fifo_rdata_o),
        .fifo_err_o    (fifo_err_o),
        .instr_req_o   (instr_req_o),
        .instr_gnt_i   (instr_gnt_i),
        .instr_addr_o  (instr_addr_o),
        .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i (instr_rdata_i),
        .instr_err_i   (instr_err_i),
        .busy_o        (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Bus-side transaction: response payload plus whether the model expects it dropped.
    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        drop;
    } bus_t;

    bus_t        bus_q[$];
    logic [32:0] exp_q[$];   // expected FIFO writes {data, err}

    // Reference model state
    logic        pend;
    logic [31:0] pend_addr;
    logic        pend_drop;
    logic [31:0] fetch_addr;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] mon_e;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: every FIFO write must match the oldest expected one.
    always @(negedge clk_i) begin
        if (rst_ni && fifo_valid_o) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL fifo_valid: unexpected write data %h expected none", fifo_rdata_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("fifo_rdata", fifo_rdata_o, mon_e[32:1]);
                check("fifo_err", 32'(fifo_err_o), 32'(mon_e[0]));
            end
        end
    end

    // One clock cycle: drive inputs, check combinational outputs, advance the model.
    // Returns 2 time units after the edge so callers can add directed checks.
    task automatic cycle(input logic req, input logic br, input logic [31:0] baddr,
                         input logic rdy, input logic gnt, input logic rv);
        logic        rv_eff;
        logic        free;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] tgt;
        bus_t        front;
        bus_t        nb;
        @(posedge clk_i);
        #1;
        rv_eff         = rv && (bus_q.size() > 0);
        req_i          = req;
        branch_i       = br;
        branch_addr_i  = baddr;
        fifo_ready_i   = rdy;
        instr_gnt_i    = gnt;
        instr_rvalid_i = rv_eff;
        if (rv_eff) begin
            instr_rdata_i = bus_q[0].data;
            instr_err_i   = bus_q[0].err;
        end else begin
            instr_rdata_i = $urandom;
            instr_err_i   = 1'b0;
        end
        #1;
        tgt  = {baddr[31:2], 2'b00};
        free = (bus_q.size() < NUM_REQS) || rv_eff;
        if (pend) begin
            exp_req  = 1'b1;
            exp_addr = pend_addr;
        end else begin
            exp_req  = ((req && rdy) || br) && free;
            exp_addr = br ? tgt : fetch_addr;
        end
        check("instr_req", 32'(instr_req_o), 32'(exp_req));
        if (exp_req) check("instr_addr", instr_addr_o, exp_addr);
        check("busy", 32'(busy_o), 32'(pend || (bus_q.size() != 0)));
        check("fifo_clear", 32'(fifo_clear_o), 32'(br));
        if (br) check("fifo_addr", fifo_addr_o, baddr);

        if (rv_eff) begin
            front = bus_q.pop_front();
            if (!front.drop && !br) exp_q.push_back({front.data, front.err});
        end
        if (br) begin
            foreach (bus_q[i]) bus_q[i].drop = 1'b1;
        end
        if (exp_req && gnt) begin
            nb.data = $urandom;
            nb.err  = ($urandom_range(0, 7) == 0);
            nb.drop = pend && (pend_drop || br);
            bus_q.push_back(nb);
            if (pend) begin
                if (br) fetch_addr = tgt;
                else if (!pend_drop) fetch_addr = pend_addr + 32'd4;
                pend = 1'b0;
            end else begin
                fetch_addr = exp_addr + 32'd4;
            end
        end else if (exp_req) begin
            if (pend) begin
                if (br) begin
                    pend_drop  = 1'b1;
                    fetch_addr = tgt;
                end
            end else begin
                pend      = 1'b1;
                pend_addr = exp_addr;
                pend_drop = 1'b0;
                if (br) fetch_addr = tgt;
            end
        end else if (br) begin
            fetch_addr = tgt;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (pend || bus_q.size() != 0); i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        end
        check("drain_done", 32'(bus_q.size()) + 32'(pend), 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        rst_ni         = 1'b0;
        req_i          = 1'b0;
        branch_i       = 1'b0;
        branch_addr_i  = '0;
        fifo_ready_i   = 1'b1;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        instr_err_i    = 1'b0;
        pend           = 1'b0;
        pend_addr      = '0;
        pend_drop      = 1'b0;
        fetch_addr     = '0;

        #3;
        check("rst_req", 32'(instr_req_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        #9;
        rst_ni = 1'b1;
        #1;
        check("post_rst_req", 32'(instr_req_o), 32'h0);
        check("post_rst_valid", 32'(fifo_valid_o), 32'h0);
        check("post_rst_clear", 32'(fifo_clear_o), 32'h0);
        check("post_rst_busy", 32'(busy_o), 32'h0);

        // Streaming after a branch to 0x80
        cycle(1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            check("stream_addr", instr_addr_o, 32'h84 + 32'(4 * i));
        end
        drain();

        // Outstanding limit
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        check("limit_req_off", 32'(instr_req_o), 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check("limit_req_resume", 32'(instr_req_o), 32'h1);

        // Branch with two outstanding
        cycle(1'b1, 1'b1, 32'h1002, 1'b1, 1'b1, 1'b0);
        check("br_clear", 32'(fifo_clear_o), 32'h1);
        check("br_fifo_addr", fifo_addr_o, 32'h1002);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check("br_target_addr", instr_addr_o, 32'h1000);
        check("br_old_dropped", 32'(fifo_valid_o), 32'h0);
        drain();

        // Branch while waiting for a grant
        cycle(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
        check("wg_hold_addr", instr_addr_o, 32'h200);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        check("wg_gnt_addr", instr_addr_o, 32'h200);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        check("wg_new_addr", instr_addr_o, 32'h400);
        drain();

        // Wrap-around and error response
        cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check("wrap_addr", instr_addr_o, 32'h0);
        bus_q[0].err = 1'b1;
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("err_valid", 32'(fifo_valid_o), 32'h1);
        check("err_flag", 32'(fifo_err_o), 32'h1);
        drain();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1);
        end
        drain();

        // Reset in the middle of operation: one outstanding and a request waiting
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk_i);
        #1;
        req_i          = 1'b0;
        branch_i       = 1'b0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        check("pre_rst_busy", 32'(busy_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        check("midrst_req", 32'(instr_req_o), 32'h0);
        check("midrst_busy", 32'(busy_o), 32'h0);
        check("midrst_valid", 32'(fifo_valid_o), 32'h0);
        bus_q.delete();
        pend       = 1'b0;
        pend_drop  = 1'b0;
        fetch_addr = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycle(1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 1'b0);
        drain();

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
